// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the opcode/func encodings the controller decodes, the ALU operation
// codes it drives, the FSM state encoding, the ALU-control class handed to
// mc_alu_ctrl, and the packed bundle of single-bit/select datapath controls.
// No ports (package).
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_IMMEXEC = 4'd8,
        S_IMMWB   = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13,
        S_HALT    = 4'd14
    } state_t;

    // How the ALU operation is chosen in the current state.
    typedef enum logic [2:0] {
        AC_NONE  = 3'd0,
        AC_ADD   = 3'd1,
        AC_SUB   = 3'd2,
        AC_RTYPE = 3'd3,
        AC_IMM   = 3'd4
    } aluClass_t;

    typedef struct packed {
        logic [1:0] pcSrc;
        logic [1:0] aluSrcB;
        logic       aluSrcA;
        logic       iorD;
        logic       regDst;
        logic       memToReg;
        logic       link;
        logic       regWrite;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    // True for the R-type func codes that map onto an ALU operation.
    function automatic logic isAluFunc(input logic [5:0] f);
        logic hit;
        hit = 1'b0;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: hit = 1'b1;
            default:                               hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/mc_alu_ctrl.sv
// ALU control decode for the multicycle controller.
// Ports:
//   aluClass     in  how the current state selects the ALU operation
//   opcode       in  latched opcode (picks ADD vs SLT for immediates)
//   func         in  latched func (picks the R-type operation)
//   aluOperation out 3-bit ALU operation code
module mc_alu_ctrl
    import mips_mc_pkg::*;
(
    input  aluClass_t  aluClass,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [2:0] aluOperation
);

    always_comb begin
        aluOperation = ALU_AND;
        case (aluClass)
            AC_ADD: aluOperation = ALU_ADD;
            AC_SUB: aluOperation = ALU_SUB;
            AC_IMM: aluOperation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            AC_RTYPE: begin
                case (func)
                    FN_ADD:  aluOperation = ALU_ADD;
                    FN_SUB:  aluOperation = ALU_SUB;
                    FN_AND:  aluOperation = ALU_AND;
                    FN_OR:   aluOperation = ALU_OR;
                    FN_SLT:  aluOperation = ALU_SLT;
                    default: aluOperation = ALU_AND;
                endcase
            end
            default: aluOperation = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit (Moore FSM).
// Ports:
//   clk, rst (async, active-low)
//   opcode, func      IR fields from the datapath, latched in DECODE
//   AluOperation      ALU op code
//   PCSrc, AluSrcB    2-bit datapath selects
//   AluSrcA .. branch single-bit datapath controls
//   illegal           high while halted on an unknown instruction
//
// state   | meaning
// FETCH   | read instruction, PC <= PC+4
// DECODE  | branch target into ALUOut, latch opcode/func, dispatch
// MEMADR  | compute lw/sw address
// MEMRD   | read data memory
// MEMWB   | write loaded word to rt
// MEMWR   | write data memory
// RTEXEC  | R-type ALU operation
// RTWB    | write ALU result to rd
// IMMEXEC | addi/slti ALU operation
// IMMWB   | write ALU result to rt
// BRANCH  | compare and conditionally load branch target
// JUMP    | load jump target
// JAL     | load jump target, write PC+4 to r31
// JR      | load PC from register A
// HALT    | unknown instruction trapped, wait for reset
module mc_controller
    import mips_mc_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [2:0] AluOperation,
    output logic [1:0] PCSrc,
    output logic [1:0] AluSrcB,
    output logic       AluSrcA,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       link,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       branch,
    output logic       illegal
);

    localparam state_t S_BAD_INSTR = ILLEGAL_TRAP ? S_HALT : S_FETCH;

    state_t     state, stateNext;
    logic [5:0] opcodeQ, funcQ;
    ctrl_t      ctrl, ctrlGated;
    aluClass_t  aluClass;
    logic [2:0] aluOpRaw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            opcodeQ <= '0;
            funcQ   <= '0;
        end else begin
            state <= stateNext;
            if (state == S_DECODE) begin
                opcodeQ <= opcode;
                funcQ   <= func;
            end
        end
    end

    // DECODE dispatches on the live IR fields; every later state uses the
    // copies captured at the end of DECODE.
    always_comb begin
        stateNext = S_FETCH;
        case (state)
            S_FETCH: stateNext = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (func == FN_JR)        stateNext = S_JR;
                        else if (isAluFunc(func)) stateNext = S_RTEXEC;
                        else                      stateNext = S_BAD_INSTR;
                    end
                    OP_LW, OP_SW:     stateNext = S_MEMADR;
                    OP_ADDI, OP_SLTI: stateNext = S_IMMEXEC;
                    OP_BEQ, OP_BNE:   stateNext = S_BRANCH;
                    OP_J:             stateNext = S_JUMP;
                    OP_JAL:           stateNext = S_JAL;
                    default:          stateNext = S_BAD_INSTR;
                endcase
            end
            S_MEMADR:  stateNext = (opcodeQ == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   stateNext = S_MEMWB;
            S_RTEXEC:  stateNext = S_RTWB;
            S_IMMEXEC: stateNext = S_IMMWB;
            S_HALT:    stateNext = S_HALT;
            default:   stateNext = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        aluClass = AC_NONE;
        case (state)
            S_FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.irWrite = 1'b1;
                ctrl.pcWrite = 1'b1;
                ctrl.aluSrcB = 2'b01;
                aluClass     = AC_ADD;
            end
            S_DECODE: begin
                ctrl.aluSrcB = 2'b11;
                aluClass     = AC_ADD;
            end
            S_MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = 2'b10;
                aluClass     = AC_ADD;
            end
            S_MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            S_RTEXEC: begin
                ctrl.aluSrcA = 1'b1;
                aluClass     = AC_RTYPE;
            end
            S_RTWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            S_IMMEXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = 2'b10;
                aluClass     = AC_IMM;
            end
            S_IMMWB: ctrl.regWrite = 1'b1;
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSrc       = 2'b01;
                ctrl.branch      = (opcodeQ == OP_BEQ);
                aluClass         = AC_SUB;
            end
            S_JUMP: begin
                ctrl.pcWrite = 1'b1;
                ctrl.pcSrc   = 2'b10;
            end
            S_JAL: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSrc    = 2'b10;
                ctrl.link     = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            S_JR: begin
                ctrl.pcWrite = 1'b1;
                ctrl.pcSrc   = 2'b11;
            end
            S_HALT:  ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

    mc_alu_ctrl uAluCtrl (
        .aluClass     (aluClass),
        .opcode       (opcodeQ),
        .func         (funcQ),
        .aluOperation (aluOpRaw)
    );

    // The state register parks in FETCH during reset, so the outputs are
    // masked with rst to keep every write strobe low while reset is held.
    assign ctrlGated    = rst ? ctrl : '0;
    assign AluOperation = rst ? aluOpRaw : 3'b000;
    assign PCSrc        = ctrlGated.pcSrc;
    assign AluSrcB      = ctrlGated.aluSrcB;
    assign AluSrcA      = ctrlGated.aluSrcA;
    assign IorD         = ctrlGated.iorD;
    assign RegDst       = ctrlGated.regDst;
    assign MemToReg     = ctrlGated.memToReg;
    assign link         = ctrlGated.link;
    assign RegWrite     = ctrlGated.regWrite;
    assign IRWrite      = ctrlGated.irWrite;
    assign MemRead      = ctrlGated.memRead;
    assign MemWrite     = ctrlGated.memWrite;
    assign PCWrite      = ctrlGated.pcWrite;
    assign PCWriteCond  = ctrlGated.pcWriteCond;
    assign branch       = ctrlGated.branch;
    assign illegal      = ctrlGated.illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one instance with ILLEGAL_TRAP=0 and one
// with ILLEGAL_TRAP=1 share the stimulus; each cycle the packed control word
// {AluOperation, PCSrc, AluSrcB, 13 flags} is compared to a hand-built value.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;

    logic [2:0] aluOpA, aluOpB;
    logic [1:0] pcSrcA, pcSrcB, srcBA, srcBB;
    logic srcAA, iorDA, regDstA, memToRegA, linkA, regWriteA, irWriteA, memReadA;
    logic memWriteA, pcWriteA, pcWcA, branchA, illegalA;
    logic srcAB, iorDB, regDstB, memToRegB, linkB, regWriteB, irWriteB, memReadB;
    logic memWriteB, pcWriteB, pcWcB, branchB, illegalB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_controller #(.ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .AluOperation(aluOpA), .PCSrc(pcSrcA), .AluSrcB(srcBA), .AluSrcA(srcAA),
        .IorD(iorDA), .RegDst(regDstA), .MemToReg(memToRegA), .link(linkA),
        .RegWrite(regWriteA), .IRWrite(irWriteA), .MemRead(memReadA),
        .MemWrite(memWriteA), .PCWrite(pcWriteA), .PCWriteCond(pcWcA),
        .branch(branchA), .illegal(illegalA)
    );

    mc_controller #(.ILLEGAL_TRAP(1'b1)) dutTrap (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .AluOperation(aluOpB), .PCSrc(pcSrcB), .AluSrcB(srcBB), .AluSrcA(srcAB),
        .IorD(iorDB), .RegDst(regDstB), .MemToReg(memToRegB), .link(linkB),
        .RegWrite(regWriteB), .IRWrite(irWriteB), .MemRead(memReadB),
        .MemWrite(memWriteB), .PCWrite(pcWriteB), .PCWriteCond(pcWcB),
        .branch(branchB), .illegal(illegalB)
    );

    wire [19:0] obsMain = {aluOpA, pcSrcA, srcBA, srcAA, iorDA, regDstA, memToRegA,
                           linkA, regWriteA, irWriteA, memReadA, memWriteA, pcWriteA,
                           pcWcA, branchA, illegalA};
    wire [19:0] obsTrap = {aluOpB, pcSrcB, srcBB, srcAB, iorDB, regDstB, memToRegB,
                           linkB, regWriteB, irWriteB, memReadB, memWriteB, pcWriteB,
                           pcWcB, branchB, illegalB};

    localparam logic [12:0] F_SRCA     = 13'h1000;
    localparam logic [12:0] F_IORD     = 13'h0800;
    localparam logic [12:0] F_REGDST   = 13'h0400;
    localparam logic [12:0] F_MEMTOREG = 13'h0200;
    localparam logic [12:0] F_LINK     = 13'h0100;
    localparam logic [12:0] F_REGWRITE = 13'h0080;
    localparam logic [12:0] F_IRWRITE  = 13'h0040;
    localparam logic [12:0] F_MEMREAD  = 13'h0020;
    localparam logic [12:0] F_MEMWRITE = 13'h0010;
    localparam logic [12:0] F_PCWRITE  = 13'h0008;
    localparam logic [12:0] F_PCWC     = 13'h0004;
    localparam logic [12:0] F_BRANCH   = 13'h0002;
    localparam logic [12:0] F_ILLEGAL  = 13'h0001;

    // {AluOperation, PCSrc, AluSrcB, flags}
    localparam logic [19:0] E_ZERO   = 20'h0;
    localparam logic [19:0] E_FETCH  = {3'b010, 2'b00, 2'b01, F_MEMREAD | F_IRWRITE | F_PCWRITE};
    localparam logic [19:0] E_DECODE = {3'b010, 2'b00, 2'b11, 13'h0};
    localparam logic [19:0] E_MEMADR = {3'b010, 2'b00, 2'b10, F_SRCA};
    localparam logic [19:0] E_MEMRD  = {3'b000, 2'b00, 2'b00, F_MEMREAD | F_IORD};
    localparam logic [19:0] E_MEMWB  = {3'b000, 2'b00, 2'b00, F_REGWRITE | F_MEMTOREG};
    localparam logic [19:0] E_MEMWR  = {3'b000, 2'b00, 2'b00, F_MEMWRITE | F_IORD};
    localparam logic [19:0] E_RTSUB  = {3'b110, 2'b00, 2'b00, F_SRCA};
    localparam logic [19:0] E_RTOR   = {3'b001, 2'b00, 2'b00, F_SRCA};
    localparam logic [19:0] E_RTWB   = {3'b000, 2'b00, 2'b00, F_REGWRITE | F_REGDST};
    localparam logic [19:0] E_ADDI   = {3'b010, 2'b00, 2'b10, F_SRCA};
    localparam logic [19:0] E_SLTI   = {3'b111, 2'b00, 2'b10, F_SRCA};
    localparam logic [19:0] E_IMMWB  = {3'b000, 2'b00, 2'b00, F_REGWRITE};
    localparam logic [19:0] E_BNE    = {3'b110, 2'b01, 2'b00, F_SRCA | F_PCWC};
    localparam logic [19:0] E_BEQ    = {3'b110, 2'b01, 2'b00, F_SRCA | F_PCWC | F_BRANCH};
    localparam logic [19:0] E_JUMP   = {3'b000, 2'b10, 2'b00, F_PCWRITE};
    localparam logic [19:0] E_JAL    = {3'b000, 2'b10, 2'b00, F_PCWRITE | F_LINK | F_REGWRITE};
    localparam logic [19:0] E_JR     = {3'b000, 2'b11, 2'b00, F_PCWRITE};
    localparam logic [19:0] E_HALT   = {3'b000, 2'b00, 2'b00, F_ILLEGAL};

    logic [19:0] expQ[$];

    task automatic checkVal(input string tag, input logic [19:0] obs, input logic [19:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, expv);
        end
    endtask

    // Resets both instances, releases at a falling edge with the given IR
    // fields and walks expQ one cycle at a time. Optionally changes the IR
    // fields just after the DECODE edge to prove the latched copy is used.
    task automatic runSeq(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input bit useTrap, input bit doGlitch,
                          input logic [5:0] gOp, input logic [5:0] gFn);
        rst = 1'b0;
        @(negedge clk);
        opcode = op;
        func   = fn;
        rst    = 1'b1;
        #1;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                if (doGlitch && i == 2) begin
                    opcode = gOp;
                    func   = gFn;
                end
                @(negedge clk);
            end
            checkVal($sformatf("%s c%0d", tag, i + 1), useTrap ? obsTrap : obsMain, expQ[i]);
        end
    endtask

    initial begin
        #2;
        checkVal("reset main", obsMain, E_ZERO);
        checkVal("reset trap", obsTrap, E_ZERO);
        @(posedge clk);
        #1;
        checkVal("reset held", obsMain, E_ZERO);

        expQ = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        runSeq("lw", 6'b100011, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        runSeq("lw latch", 6'b100011, 6'd0, 1'b0, 1'b1, 6'b101011, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_RTSUB, E_RTWB, E_FETCH};
        runSeq("sub", 6'b000000, 6'b100010, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_RTOR, E_RTWB, E_FETCH};
        runSeq("or latch", 6'b000000, 6'b100101, 1'b0, 1'b1, 6'b000000, 6'b100010);

        expQ = '{E_FETCH, E_DECODE, E_ADDI, E_IMMWB, E_FETCH};
        runSeq("addi", 6'b001000, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_SLTI, E_IMMWB, E_FETCH};
        runSeq("slti", 6'b001010, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_BNE, E_FETCH};
        runSeq("bne", 6'b000101, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_BEQ, E_FETCH};
        runSeq("beq", 6'b000100, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        runSeq("j", 6'b000010, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_JAL, E_FETCH};
        runSeq("jal", 6'b000011, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_JR, E_FETCH};
        runSeq("jr", 6'b000000, 6'b001000, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_FETCH, E_DECODE};
        runSeq("ill nop", 6'b111111, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_HALT, E_HALT, E_HALT, E_HALT};
        runSeq("ill trap", 6'b111111, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);
        rst = 1'b0;
        #1;
        checkVal("halt cleared", obsTrap, E_ZERO);

        expQ = '{E_FETCH, E_DECODE, E_HALT, E_HALT};
        runSeq("bad func trap", 6'b000000, 6'b111111, 1'b1, 1'b0, 6'd0, 6'd0);

        expQ = '{E_FETCH, E_DECODE, E_FETCH};
        runSeq("bad func nop", 6'b000000, 6'b111111, 1'b0, 1'b0, 6'd0, 6'd0);

        // Reset pulled in the middle of MEMWR must drop MemWrite at once.
        expQ = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        runSeq("sw", 6'b101011, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        #2;
        rst = 1'b0;
        #1;
        checkVal("sw abort async", obsMain, E_ZERO);
        @(posedge clk);
        #1;
        checkVal("sw abort held", obsMain, E_ZERO);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("after abort c1", obsMain, E_FETCH);
        @(negedge clk);
        checkVal("after abort c2", obsMain, E_DECODE);
        @(negedge clk);
        checkVal("after abort c3", obsMain, E_MEMADR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter: ILLEGAL_TRAP, default 0, 1 = unknown opcode/func halts the core in HALT until reset; 0 = treated as NOP.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock; all state changes on rising edge
 rst  in  1  asynchronous, active-low reset
 opcode  in  6  IR[31:26] from datapath
 func  in  6  IR[5:0] from datapath
 AluOperation  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
 PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A
 AluSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
 AluSrcA, IorD, RegDst, MemToReg, link, RegWrite, IRWrite, MemRead, MemWrite, PCWrite, PCWriteCond, branch  out  1 each  datapath controls
 illegal  out  1  high while in HALT

Function
REQ-003 SHALL be a Moore FSM; every output decoded from state only (AluOperation in RTEXEC also uses latched func); each output 0 unless listed for the current state.
REQ-004 States and asserted outputs:
 FETCH: MemRead, IRWrite, PCWrite, AluSrcB=01, AluOperation=ADD, PCSrc=00, IorD=0, AluSrcA=0
 DECODE: AluSrcB=11, AluOperation=ADD (branch target into ALUOut)
 MEMADR: AluSrcA, AluSrcB=10, ADD
 MEMRD: MemRead, IorD
 MEMWB: RegWrite, MemToReg, RegDst=0
 MEMWR: MemWrite, IorD
 RTEXEC: AluSrcA, AluSrcB=00, AluOperation from func
 RTWB: RegWrite, RegDst
 IMMEXEC: AluSrcA, AluSrcB=10, ADD (addi) or SLT (slti)
 IMMWB: RegWrite, RegDst=0, MemToReg=0
 BRANCH: AluSrcA, AluSrcB=00, SUB, PCWriteCond, PCSrc=01, branch=1 for beq, 0 for bne
 JUMP: PCWrite, PCSrc=10
 JAL: PCWrite, PCSrc=10, link, RegWrite
 JR: PCWrite, PCSrc=11
 HALT: illegal only
REQ-005 Transitions: FETCH->DECODE always; DECODE by opcode: 000000 -> RTEXEC (func 001000 -> JR); 100011/101011 -> MEMADR; 001000/001010 -> IMMEXEC; 000100/000101 -> BRANCH; 000010 -> JUMP; 000011 -> JAL; MEMADR -> MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; RTEXEC->RTWB; IMMEXEC->IMMWB; MEMWB, MEMWR, RTWB, IMMWB, BRANCH, JUMP, JAL, JR -> FETCH.
REQ-006 R-type func map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
REQ-007 Unknown opcode or R-type func in DECODE: ILLEGAL_TRAP=0 -> FETCH (NOP, PC already +4); ILLEGAL_TRAP=1 -> HALT, held until reset.
REQ-008 opcode/func SHALL be latched into internal registers in DECODE and used thereafter (IR held stable; latch guards against IR glitches).
REQ-009 Cycles per instruction: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3.
REQ-010 JAL SHALL write PC+4 to r31 in the same cycle the PC loads the jump target.

Reset
REQ-011 rst low SHALL force state FETCH and latched opcode/func to 0 asynchronously, and force all outputs to 0 while low (no PC/IR/memory write during reset).
REQ-012 Reset asserted mid-instruction SHALL abort it; first rising edge after release executes FETCH.

Structure
REQ-013 Opcode, func, AluOperation codes and state encoding SHALL live in a shared package mips_mc_pkg.
REQ-014 ALU-control decode (state class + func -> AluOperation) SHALL be sub-module mc_alu_ctrl.

Verification
REQ-015 Reset release, opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; MemRead in cycles 1 and 4, RegWrite+MemToReg in cycle 5.
REQ-016 opcode=000000, func=100010 -> RTEXEC AluOperation=110, RTWB RegWrite=1 RegDst=1; back in FETCH on cycle 5.
REQ-017 opcode=000101 -> BRANCH cycle 3 with PCWriteCond=1, branch=0, PCSrc=01, AluOperation=110; opcode=000100 same with branch=1.
REQ-018 opcode=000011 -> cycle 3 link=1, RegWrite=1, PCWrite=1, PCSrc=10; opcode=000000 func=001000 -> PCSrc=11.
REQ-019 opcode=111111 with ILLEGAL_TRAP=0 -> FETCH on cycle 3, no writes; with ILLEGAL_TRAP=1 -> illegal=1 held, all other outputs 0, until rst low.
REQ-020 rst driven low during MEMWR -> MemWrite drops immediately (asynchronous), all outputs 0; after release first cycle is FETCH.
